// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the Y86-64 pipeline datapath and the
// central hazard controller. The datapath (master) drives pipeline state;
// the controller (slave) returns the per-register stall/bubble controls and
// the performance counters.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       D_Ins_Code;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_Ins_Code;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [2:0]       m_stat;
  logic [2:0]       W_stat;

  logic             F_stall;
  logic             D_tostall;
  logic             D_toBubble;
  logic             E_toBubble;
  logic             M_toBubble;
  logic             W_tostall;
  logic             set_cc_en;
  logic             ret_release;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] ret_cnt;

  modport master (
    output D_Ins_Code, d_srcA, d_srcB, E_Ins_Code, E_dstM, e_Cnd, m_stat, W_stat,
    input  F_stall, D_tostall, D_toBubble, E_toBubble, M_toBubble, W_tostall,
    input  set_cc_en, ret_release, halted, stall_cnt, bubble_cnt, ret_cnt
  );

  modport slave (
    input  D_Ins_Code, d_srcA, d_srcB, E_Ins_Code, E_dstM, e_Cnd, m_stat, W_stat,
    output F_stall, D_tostall, D_toBubble, E_toBubble, M_toBubble, W_tostall,
    output set_cc_en, ret_release, halted, stall_cnt, bubble_cnt, ret_cnt
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central hazard controller for the five-stage Y86-64 pipeline: load/use
// interlock, mispredict squash, ret sequencing and exception drain/halt.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is
// defined; otherwise the counter outputs are tied to zero.
module pipeline_hazard_controller #(
  parameter int RET_BUBBLES = 3,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  pipeline_hazard_controller_if.slave hz
);

  localparam int RCW = (RET_BUBBLES > 2) ? $clog2(RET_BUBBLES) : 1;
  localparam logic [RCW-1:0] RCNT_LOAD = RCW'(RET_BUBBLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [RCW-1:0] rcnt, rcnt_n;
  logic           rel_q, rel_n;
  logic           ret_start;
  logic           lu, mp, exc_m, exc_w;
  logic           f_stall, d_stall, d_bub, e_bub, m_bub, w_stall, set_cc;

  assign lu    = ((hz.E_Ins_Code == 4'h5) || (hz.E_Ins_Code == 4'hB)) &&
                 (hz.E_dstM != 4'hF) &&
                 ((hz.E_dstM == hz.d_srcA) || (hz.E_dstM == hz.d_srcB));
  assign mp    = (hz.E_Ins_Code == 4'h7) && !hz.e_Cnd;
  assign exc_m = (hz.m_stat != 3'd0);
  assign exc_w = (hz.W_stat != 3'd0);

  // FSM state, ret down-counter and the one-cycle ret release flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rcnt  <= '0;
      rel_q <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      rel_q <= rel_n;
    end
  end

  // Next state and same-cycle controls; a writeback exception preempts all
  // hazard terms, and a frozen pipeline also blocks condition-code writes.
  always_comb begin
    state_n   = state;
    rcnt_n    = rcnt;
    rel_n     = 1'b0;
    ret_start = 1'b0;
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    d_bub     = 1'b0;
    e_bub     = 1'b0;
    m_bub     = 1'b0;
    w_stall   = 1'b0;
    set_cc    = 1'b1;
    case (state)
      RUN: begin
        if (exc_w) begin
          state_n = HALTED;
        end else if (mp) begin
          d_bub = 1'b1;
          e_bub = 1'b1;
        end else if (lu) begin
          f_stall = 1'b1;
          d_stall = 1'b1;
          e_bub   = 1'b1;
        end else if (hz.D_Ins_Code == 4'h9) begin
          f_stall   = 1'b1;
          d_bub     = 1'b1;
          ret_start = 1'b1;
          if (RET_BUBBLES > 1) begin
            state_n = RET_WAIT;
            rcnt_n  = RCNT_LOAD;
          end else begin
            rel_n = 1'b1;
          end
        end
      end
      RET_WAIT: begin
        f_stall = 1'b1;
        d_bub   = 1'b1;
        if (exc_w) begin
          state_n = HALTED;
          rcnt_n  = '0;
        end else begin
          if (mp) e_bub = 1'b1;
          rcnt_n = rcnt - RCW'(1);
          if (rcnt == RCW'(1)) begin
            state_n = RUN;
            rcnt_n  = '0;
            rel_n   = 1'b1;
          end
        end
      end
      HALTED: begin
        f_stall = 1'b1;
        d_bub   = 1'b1;
        e_bub   = 1'b1;
        m_bub   = 1'b1;
        w_stall = 1'b1;
        set_cc  = 1'b0;
      end
      default: begin
        state_n = RUN;
        rcnt_n  = '0;
      end
    endcase
    if (exc_m || exc_w) begin
      m_bub  = 1'b1;
      set_cc = 1'b0;
    end
    if (exc_w) w_stall = 1'b1;
    if (!rst_n) begin
      f_stall = 1'b0;
      d_stall = 1'b0;
      d_bub   = 1'b1;
      e_bub   = 1'b1;
      m_bub   = 1'b1;
      w_stall = 1'b0;
      set_cc  = 1'b0;
    end
  end

  assign hz.F_stall     = f_stall;
  assign hz.D_tostall   = d_stall;
  assign hz.D_toBubble  = d_bub;
  assign hz.E_toBubble  = e_bub;
  assign hz.M_toBubble  = m_bub;
  assign hz.W_tostall   = w_stall;
  assign hz.set_cc_en   = set_cc;
  assign hz.ret_release = rel_q;
  assign hz.halted      = (state == HALTED);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, ret_cnt;

  // Saturating performance counters, frozen while the pipeline is halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      ret_cnt    <= '0;
    end else if (state != HALTED) begin
      if (f_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((d_bub || e_bub || m_bub) && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (ret_start && (ret_cnt != '1)) ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt  = stall_cnt;
  assign hz.bubble_cnt = bubble_cnt;
  assign hz.ret_cnt    = ret_cnt;
`else
  logic unused_ret_start;
  assign unused_ret_start = ret_start;
  assign hz.stall_cnt     = '0;
  assign hz.bubble_cnt    = '0;
  assign hz.ret_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios with
// literal expectations, then randomized pipeline state compared every cycle
// against a behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;

  localparam int RB    = 3;
  localparam int CNT_W = 32;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hz();

  pipeline_hazard_controller #(.RET_BUBBLES(RB), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bub;
    logic e_bub;
    logic m_bub;
    logic w_stall;
    logic set_cc;
    logic ret_rel;
    logic halted;
    logic ret_go;
  } exp_t;

  // Model state: frozen flag, ret bubbles still owed after this cycle,
  // release pending for this cycle, and counter totals.
  logic   m_halted   = 1'b0;
  int     m_ret_left = 0;
  logic   m_rel      = 1'b0;
  longint m_stall    = 0;
  longint m_bubble   = 0;
  longint m_ret      = 0;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Required controls for the current inputs, derived from the hazard rules.
  function automatic exp_t model_out();
    exp_t e;
    logic lu_t, mp_t, em, ew;
    e = '0;
    e.set_cc = 1'b1;
    lu_t = ((hz.E_Ins_Code == 4'h5) || (hz.E_Ins_Code == 4'hB)) && (hz.E_dstM != 4'hF) &&
           ((hz.E_dstM == hz.d_srcA) || (hz.E_dstM == hz.d_srcB));
    mp_t = (hz.E_Ins_Code == 4'h7) && !hz.e_Cnd;
    em   = hz.m_stat != 0;
    ew   = hz.W_stat != 0;
    if (!rst_n) begin
      e = '0;
      e.d_bub = 1'b1; e.e_bub = 1'b1; e.m_bub = 1'b1;
      return e;
    end
    if (m_halted) begin
      e.f_stall = 1'b1; e.d_bub = 1'b1; e.e_bub = 1'b1; e.m_bub = 1'b1;
      e.w_stall = 1'b1; e.halted = 1'b1; e.set_cc = 1'b0;
      return e;
    end
    e.ret_rel = m_rel;
    if (m_ret_left > 0) begin
      e.f_stall = 1'b1; e.d_bub = 1'b1;
      if (mp_t && !ew) e.e_bub = 1'b1;
    end else if (ew) begin
    end else if (mp_t) begin
      e.d_bub = 1'b1; e.e_bub = 1'b1;
    end else if (lu_t) begin
      e.f_stall = 1'b1; e.d_stall = 1'b1; e.e_bub = 1'b1;
    end else if (hz.D_Ins_Code == 4'h9) begin
      e.f_stall = 1'b1; e.d_bub = 1'b1; e.ret_go = 1'b1;
    end
    if (em || ew) begin
      e.m_bub = 1'b1; e.set_cc = 1'b0;
    end
    if (ew) e.w_stall = 1'b1;
    return e;
  endfunction

  // Advance the model at each clock edge.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    logic ew;
    if (!rst_n) begin
      m_halted = 1'b0; m_ret_left = 0; m_rel = 1'b0;
      m_stall = 0; m_bubble = 0; m_ret = 0;
    end else begin
      e  = model_out();
      ew = hz.W_stat != 0;
      if (!m_halted) begin
        if (e.f_stall && m_stall < CNT_MAX) m_stall++;
        if ((e.d_bub || e.e_bub || e.m_bub) && m_bubble < CNT_MAX) m_bubble++;
        if (e.ret_go && m_ret < CNT_MAX) m_ret++;
        if (ew) begin
          m_halted = 1'b1; m_ret_left = 0; m_rel = 1'b0;
        end else if (m_ret_left > 0) begin
          m_ret_left--;
          m_rel = (m_ret_left == 0);
        end else if (e.ret_go) begin
          m_ret_left = RB - 1;
          m_rel = (RB == 1);
        end else begin
          m_rel = 1'b0;
        end
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    check_output("F_stall",     hz.F_stall,     e.f_stall);
    check_output("D_tostall",   hz.D_tostall,   e.d_stall);
    check_output("D_toBubble",  hz.D_toBubble,  e.d_bub);
    check_output("E_toBubble",  hz.E_toBubble,  e.e_bub);
    check_output("M_toBubble",  hz.M_toBubble,  e.m_bub);
    check_output("W_tostall",   hz.W_tostall,   e.w_stall);
    check_output("set_cc_en",   hz.set_cc_en,   e.set_cc);
    check_output("ret_release", hz.ret_release, e.ret_rel);
    check_output("halted",      hz.halted,      e.halted);
`ifdef HAZ_PERF_CNT_EN
    check_output("stall_cnt",   hz.stall_cnt,   m_stall);
    check_output("bubble_cnt",  hz.bubble_cnt,  m_bubble);
    check_output("ret_cnt",     hz.ret_cnt,     m_ret);
`else
    check_output("stall_cnt",   hz.stall_cnt,   0);
    check_output("bubble_cnt",  hz.bubble_cnt,  0);
    check_output("ret_cnt",     hz.ret_cnt,     0);
`endif
  end

  task automatic apply_stimulus(input logic [3:0] d_ic, input logic [3:0] sa, input logic [3:0] sb,
                                input logic [3:0] e_ic, input logic [3:0] dm, input logic cnd,
                                input logic [2:0] ms, input logic [2:0] ws);
    @(posedge clk);
    #1;
    hz.D_Ins_Code = d_ic; hz.d_srcA = sa; hz.d_srcB = sb;
    hz.E_Ins_Code = e_ic; hz.E_dstM = dm; hz.e_Cnd = cnd;
    hz.m_stat = ms; hz.W_stat = ws;
  endtask

  task automatic apply_idle();
    apply_stimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] d_ic, sa, sb, e_ic, dm;
    logic [2:0] ms, ws;
    logic       cnd;
    int         r;

    rst_n = 1'b0;
    hz.D_Ins_Code = 4'h1; hz.d_srcA = 4'hF; hz.d_srcB = 4'hF;
    hz.E_Ins_Code = 4'h1; hz.E_dstM = 4'hF; hz.e_Cnd = 1'b0;
    hz.m_stat = 3'd0; hz.W_stat = 3'd0;

    // Reset values.
    repeat (2) @(negedge clk);
    check_output("rst_D_toBubble", hz.D_toBubble, 1);
    check_output("rst_E_toBubble", hz.E_toBubble, 1);
    check_output("rst_M_toBubble", hz.M_toBubble, 1);
    check_output("rst_F_stall",    hz.F_stall,    0);
    check_output("rst_set_cc_en",  hz.set_cc_en,  0);
    check_output("rst_halted",     hz.halted,     0);
    #2 rst_n = 1'b1;

    // Load/use: mrmovq to r3 in E, decode reads r3.
    apply_stimulus(4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    check_output("lu_F_stall",    hz.F_stall,    1);
    check_output("lu_D_tostall",  hz.D_tostall,  1);
    check_output("lu_E_toBubble", hz.E_toBubble, 1);
    check_output("lu_D_toBubble", hz.D_toBubble, 0);
    apply_idle();
    @(negedge clk);
    check_output("lu_after_F_stall", hz.F_stall,   0);
    check_output("lu_after_D_stall", hz.D_tostall, 0);
    check_output("lu_after_set_cc",  hz.set_cc_en, 1);

    // Ret: three D bubbles, then one release cycle.
    apply_stimulus(4'h9, 4'h4, 4'hF, 4'h1, 4'hF, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    check_output("ret_c1_D_toBubble", hz.D_toBubble, 1);
    check_output("ret_c1_F_stall",    hz.F_stall,    1);
    for (int c = 2; c <= 3; c++) begin
      apply_idle();
      @(negedge clk);
      check_output("ret_cN_D_toBubble", hz.D_toBubble, 1);
      check_output("ret_cN_release",    hz.ret_release, 0);
    end
    apply_idle();
    @(negedge clk);
    check_output("ret_c4_release",    hz.ret_release, 1);
    check_output("ret_c4_D_toBubble", hz.D_toBubble,  0);
`ifdef HAZ_PERF_CNT_EN
    check_output("ret_c4_ret_cnt",    hz.ret_cnt,     1);
`endif
    apply_idle();
    @(negedge clk);
    check_output("ret_c5_release", hz.ret_release, 0);

    // Mispredict with ret in D: squash only, no ret sequence.
    apply_stimulus(4'h9, 4'h4, 4'hF, 4'h7, 4'hF, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    check_output("mp_D_toBubble", hz.D_toBubble, 1);
    check_output("mp_E_toBubble", hz.E_toBubble, 1);
    check_output("mp_F_stall",    hz.F_stall,    0);
    apply_idle();
    @(negedge clk);
    check_output("mp_after_D_toBubble", hz.D_toBubble, 0);
    apply_idle();
    @(negedge clk);
    check_output("mp_after_release", hz.ret_release, 0);

    // Load/use combined with ret: stall first, then three bubbles.
    apply_stimulus(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    check_output("luret_D_tostall",  hz.D_tostall,  1);
    check_output("luret_D_toBubble", hz.D_toBubble, 0);
    apply_stimulus(4'h9, 4'h3, 4'hF, 4'h1, 4'hF, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    check_output("luret_b1", hz.D_toBubble, 1);
    apply_idle();
    @(negedge clk);
    check_output("luret_b2", hz.D_toBubble, 1);
    apply_idle();
    @(negedge clk);
    check_output("luret_b3", hz.D_toBubble, 1);
    apply_idle();
    @(negedge clk);
    check_output("luret_release", hz.ret_release, 1);
    check_output("luret_no_b4",   hz.D_toBubble,  0);

    // Exception drain then halt.
    apply_stimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 3'd2, 3'd0);
    @(negedge clk);
    check_output("excm_M_toBubble", hz.M_toBubble, 1);
    check_output("excm_set_cc_en",  hz.set_cc_en,  0);
    check_output("excm_W_tostall",  hz.W_tostall,  0);
    apply_stimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 3'd0, 3'd2);
    @(negedge clk);
    check_output("excw_W_tostall", hz.W_tostall, 1);
    check_output("excw_halted",    hz.halted,    0);
    for (int c = 0; c < 3; c++) begin
      apply_idle();
      @(negedge clk);
      check_output("halt_halted",  hz.halted,  1);
      check_output("halt_F_stall", hz.F_stall, 1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("halt_rst_halted",  hz.halted,     0);
    check_output("halt_rst_D_bub",   hz.D_toBubble, 1);
    check_output("halt_rst_W_stall", hz.W_tostall,  0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Async reset while the ret counter sits at 1.
    apply_stimulus(4'h9, 4'h4, 4'hF, 4'h1, 4'hF, 1'b0, 3'd0, 3'd0);
    apply_idle();
    apply_idle();
    #2 rst_n = 1'b0;
    #1;
    check_output("rw_rst_F_stall", hz.F_stall,     0);
    check_output("rw_rst_D_bub",   hz.D_toBubble,  1);
    check_output("rw_rst_release", hz.ret_release, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply_idle();
      @(negedge clk);
      check_output("rw_no_release", hz.ret_release, 0);
    end

    // Randomized pipeline state against the model.
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 300; c++) begin
        r    = $urandom_range(0, 99);
        d_ic = (r < 20) ? 4'h9 : 4'($urandom_range(0, 11));
        sa   = ($urandom_range(0, 99) < 20) ? 4'hF : 4'($urandom_range(0, 4));
        sb   = ($urandom_range(0, 99) < 20) ? 4'hF : 4'($urandom_range(0, 4));
        r    = $urandom_range(0, 3);
        e_ic = (r == 0) ? 4'h5 : (r == 1) ? 4'hB : (r == 2) ? 4'h7 : 4'($urandom_range(0, 6));
        dm   = ($urandom_range(0, 99) < 15) ? 4'hF : 4'($urandom_range(0, 4));
        cnd  = 1'($urandom_range(0, 1));
        ms   = ($urandom_range(0, 99) < 4) ? 3'($urandom_range(1, 3)) : 3'd0;
        ws   = ($urandom_range(0, 99) < 2) ? 3'($urandom_range(1, 3)) : 3'd0;
        apply_stimulus(d_ic, sa, sb, e_ic, dm, cnd, ms, ws);
        if ($urandom_range(0, 99) == 0) begin
          #1 rst_n = 1'b0;
          @(posedge clk);
          @(negedge clk);
          #2 rst_n = 1'b1;
        end else if (m_halted && $urandom_range(0, 7) == 0) begin
          do_reset();
        end
      end
      do_reset();
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central control unit for the five-stage Y86-64 pipeline. It generates the stall and bubble controls consumed by the F, D, E, M and W pipeline registers, including the D-register `D_tostall`/`D_toBubble` pair. It covers load/use interlock, mispredicted-branch squash, ret sequencing and exception drain/halt. Ret handling and halt are sequenced by a registered FSM; all other controls are same-cycle combinational functions of pipeline state and FSM state.

## Interface
Parameters:
- `RET_BUBBLES`, default 3: number of D bubbles inserted per ret.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` input 1: pipeline clock. All state updates on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `D_Ins_Code` input 4: icode in the D register.
- `d_srcA`, `d_srcB` input 4 each: decode source registers; 4'hF means none.
- `E_Ins_Code` input 4: icode in the E register.
- `E_dstM` input 4: E load destination register.
- `e_Cnd` input 1: branch condition computed in execute.
- `m_stat`, `W_stat` input 3 each: stage status codes. 0 AOK, 1 HLT, 2 ADR, 3 INS.
- `F_stall` output 1: hold the PC register.
- `D_tostall` output 1: hold the D register.
- `D_toBubble` output 1: load a nop into the D register.
- `E_toBubble` output 1: load a nop into the E register.
- `M_toBubble` output 1: load a nop into the M register.
- `W_tostall` output 1: hold the W register.
- `set_cc_en` output 1: condition-code write enable.
- `ret_release` output 1: F selects `W_valM` as the next PC this cycle.
- `halted` output 1: the pipeline is frozen.
- `stall_cnt`, `bubble_cnt`, `ret_cnt` output `CNT_W` each: performance counters.

## Operation
Icodes: 5 mrmovq, 7 jXX, 9 ret, B popq.

Hazard terms (combinational):
- `lu` (load/use) = (`E_Ins_Code` is 5 or B) && `E_dstM` != F && (`E_dstM` == `d_srcA` || `E_dstM` == `d_srcB`).
- `mp` (mispredict) = `E_Ins_Code` == 7 && !`e_Cnd`.
- `exc_m` = `m_stat` != 0.
- `exc_w` = `W_stat` != 0.

FSM states: RUN, RET_WAIT (with down-counter `rcnt`), HALTED.
- RUN, `exc_w`: go to HALTED.
- RUN, `mp`: `D_toBubble`=1 and `E_toBubble`=1. A ret in D is on the wrong path and is ignored. Stay in RUN.
- RUN, `lu`: `F_stall`=1, `D_tostall`=1, `E_toBubble`=1. Ret entry is deferred to the following cycle. Stay in RUN.
- RUN, `D_Ins_Code`==9: `F_stall`=1, `D_toBubble`=1. Set `rcnt`=`RET_BUBBLES`-1 and go to RET_WAIT.
- RET_WAIT: `F_stall`=1, `D_toBubble`=1, `rcnt` decrements. When `rcnt`==1, return to RUN with `ret_release`=1 in the first RUN cycle.
- RET_WAIT, `exc_w`: go to HALTED.
- HALTED: `F_stall`, `D_toBubble`, `E_toBubble`, `M_toBubble`, `W_tostall`, `halted` all 1. The state is sticky until `rst_n` is low.

Exception terms, in any state:
- `exc_m` || `exc_w` forces `M_toBubble`=1 and `set_cc_en`=0.
- `exc_w` forces `W_tostall`=1.

Priority: HALTED > `exc_w` > `mp` > `lu` > ret. `D_tostall` and `D_toBubble` are never both 1.

Default outputs: all controls 0 except `set_cc_en`=1.

## Timing
- Reset while `rst_n` is low:
  - State is RUN and `rcnt` is 0.
  - `D_toBubble`, `E_toBubble`, `M_toBubble` are 1.
  - `F_stall`, `D_tostall`, `W_tostall`, `ret_release`, `halted`, `set_cc_en` are 0.
  - All counters are 0.
- A reset assertion mid-RET_WAIT or mid-HALTED returns to RUN immediately, asynchronously.
- Controls are valid before each posedge and are sampled by the pipeline registers at that edge. There is zero-cycle latency from hazard inputs to controls.
- Ret sequence: D bubbles on exactly `RET_BUBBLES` consecutive cycles. `ret_release` is high in cycle `RET_BUBBLES`+1 relative to ret in D (cycle 1).
- A mispredict that arrives while in RET_WAIT adds `E_toBubble`=1. The FSM continues counting.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `F_stall`=1.
  - `bubble_cnt` increments on every cycle where any bubble output is 1.
  - `ret_cnt` increments on each entry to RET_WAIT.
  - Counters saturate at all-ones. They hold in HALTED.
- `HAZ_PERF_CNT_EN` undefined: the counter logic is removed and all three counter outputs are tied to 0.

## Test plan
- Load/use: mrmovq to r3 in E with `d_srcA`=3 → one cycle of `F_stall`=1, `D_tostall`=1, `E_toBubble`=1. The following cycle all controls are 0.
- Ret: `D_Ins_Code`=9 → `D_toBubble`=1 for 3 cycles, then `ret_release`=1 for one cycle. State returns to RUN and `ret_cnt` reads 1.
- Mispredict with ret in D: `E_Ins_Code`=7, `e_Cnd`=0, `D_Ins_Code`=9 → `D_toBubble`=1 and `E_toBubble`=1 for one cycle. RET_WAIT is not entered.
- Load/use combined with ret: `lu` true and ret in D → stall first. Bubbles start on the next cycle, giving `RET_BUBBLES` bubbles in total.
- Exception: `m_stat`=2 → `M_toBubble`=1 and `set_cc_en`=0. The next cycle `W_stat`=2 → `W_tostall`=1, HALTED is entered and `halted` stays 1 until `rst_n` is pulsed.
- Async reset during RET_WAIT (`rcnt`=1) → RUN immediately with reset output values. `ret_release` never asserts.
